dmi_rsp_agent: RTL and testbench

DM-side DMI responder: accepts DMI requests (addr/data/op) issued by the DTM register bank, performs the access on the Debug Module register-file port, and returns a DMI response carrying status op and read data. Runs in the `dtm_clk` domain and connects directly to the DTM's `dmi_req_*` / `dmi_rsp_*` ports. Handles one transaction at a time. A timeout converts a stalled register access into a failure response.

---
 rtl/debug_pack.sv | 28 ++
 rtl/dmi_rsp_agent.sv | 128 ++++++++++++
 tb/tb_dmi_rsp_agent.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/debug_pack.sv
// Shared debug-module definitions: DMI op codes, response status codes,
// the DMI responder state encoding and the response record.
package debug_pack;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [1:0] RSP_SUCS = 2'b00;
  localparam logic [1:0] RSP_FAIL = 2'b10;
  localparam logic [1:0] RSP_BUSY = 2'b11;

  localparam int DMI_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dmi_agent_state_e;

  typedef struct packed {
    logic [DMI_DATA_W-1:0] data;
    logic [1:0]            op;
  } dmi_rsp_t;

endpackage

// File: rtl/dmi_rsp_agent.sv
// DM-side DMI responder: turns one DMI request at a time into a register-file
// access and returns a status/data response, with a timeout on stalled accesses.
module dmi_rsp_agent
  import debug_pack::*;
#(
  parameter int DMI_ADDR = 7,
  parameter int DMI_DATA = 32,
  parameter int TIMEOUT  = 64
) (
  input  logic                dtm_clk,
  input  logic                dtm_rst_n,
  input  logic                dmi_req_vld,
  output logic                dmi_req_rdy,
  input  logic [DMI_ADDR-1:0] dmi_req_addr,
  input  logic [DMI_DATA-1:0] dmi_req_data,
  input  logic [1:0]          dmi_req_op,
  output logic                dmi_rsp_vld,
  input  logic                dmi_rsp_rdy,
  output logic [DMI_DATA-1:0] dmi_rsp_data,
  output logic [1:0]          dmi_rsp_op,
  input  logic                dm_busy,
  output logic                reg_req_vld,
  input  logic                reg_req_rdy,
  output logic                reg_req_we,
  output logic [DMI_ADDR-1:0] reg_req_addr,
  output logic [DMI_DATA-1:0] reg_req_wdata,
  input  logic                reg_rsp_vld,
  input  logic [DMI_DATA-1:0] reg_rsp_data,
  input  logic                reg_rsp_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  dmi_agent_state_e    state;
  logic [1:0]          op_q;
  logic [DMI_ADDR-1:0] addr_q;
  logic [DMI_DATA-1:0] data_q;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;

  assign dmi_req_rdy   = (state == IDLE);
  assign reg_req_we    = (op_q == OP_WRITE);
  assign reg_req_addr  = addr_q;
  assign reg_req_wdata = data_q;
  assign cnt_nxt       = (cnt == TMAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge dtm_clk or negedge dtm_rst_n) begin
    if (!dtm_rst_n) begin
      state        <= IDLE;
      op_q         <= OP_NOP;
      addr_q       <= '0;
      data_q       <= '0;
      cnt          <= '0;
      reg_req_vld  <= 1'b0;
      dmi_rsp_vld  <= 1'b0;
      dmi_rsp_op   <= RSP_SUCS;
      dmi_rsp_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dmi_req_vld) begin
            op_q   <= dmi_req_op;
            addr_q <= dmi_req_addr;
            data_q <= dmi_req_data;
            cnt    <= '0;
            if (dmi_req_op == OP_RSVD) begin
              state        <= RESP;
              dmi_rsp_vld  <= 1'b1;
              dmi_rsp_op   <= RSP_FAIL;
              dmi_rsp_data <= '0;
            end else if (dmi_req_op == OP_NOP) begin
              state        <= RESP;
              dmi_rsp_vld  <= 1'b1;
              dmi_rsp_op   <= RSP_SUCS;
              dmi_rsp_data <= '0;
            end else if (dm_busy) begin
              state        <= RESP;
              dmi_rsp_vld  <= 1'b1;
              dmi_rsp_op   <= RSP_BUSY;
              dmi_rsp_data <= '0;
            end else begin
              state       <= ISSUE;
              reg_req_vld <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt <= cnt_nxt;
          // Timeout beats a same-cycle accept: the access is abandoned.
          if (cnt == TMAX) begin
            state        <= RESP;
            reg_req_vld  <= 1'b0;
            dmi_rsp_vld  <= 1'b1;
            dmi_rsp_op   <= RSP_FAIL;
            dmi_rsp_data <= '0;
          end else if (reg_req_rdy) begin
            state       <= WAIT;
            reg_req_vld <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt_nxt;
          // A completion in the timeout cycle still counts as a real response.
          if (reg_rsp_vld) begin
            state        <= RESP;
            dmi_rsp_vld  <= 1'b1;
            dmi_rsp_op   <= reg_rsp_err ? RSP_FAIL : RSP_SUCS;
            dmi_rsp_data <= (op_q == OP_READ && !reg_rsp_err) ? reg_rsp_data : '0;
          end else if (cnt == TMAX) begin
            state        <= RESP;
            dmi_rsp_vld  <= 1'b1;
            dmi_rsp_op   <= RSP_FAIL;
            dmi_rsp_data <= '0;
          end
        end
        RESP: begin
          if (dmi_rsp_rdy) begin
            state       <= IDLE;
            dmi_rsp_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_rsp_agent.sv
// Directed bench for dmi_rsp_agent with TIMEOUT=8; expected values are hand-derived.
module tb_dmi_rsp_agent;
  import debug_pack::*;

  logic        dtm_clk = 1'b0;
  logic        dtm_rst_n = 1'b0;
  logic        dmi_req_vld = 1'b0;
  logic        dmi_req_rdy;
  logic [6:0]  dmi_req_addr = '0;
  logic [31:0] dmi_req_data = '0;
  logic [1:0]  dmi_req_op = '0;
  logic        dmi_rsp_vld;
  logic        dmi_rsp_rdy = 1'b0;
  logic [31:0] dmi_rsp_data;
  logic [1:0]  dmi_rsp_op;
  logic        dm_busy = 1'b0;
  logic        reg_req_vld;
  logic        reg_req_rdy = 1'b0;
  logic        reg_req_we;
  logic [6:0]  reg_req_addr;
  logic [31:0] reg_req_wdata;
  logic        reg_rsp_vld = 1'b0;
  logic [31:0] reg_rsp_data = '0;
  logic        reg_rsp_err = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  dmi_rsp_agent #(.DMI_ADDR(7), .DMI_DATA(32), .TIMEOUT(8)) dut (
    .dtm_clk(dtm_clk), .dtm_rst_n(dtm_rst_n),
    .dmi_req_vld(dmi_req_vld), .dmi_req_rdy(dmi_req_rdy),
    .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
    .dmi_rsp_vld(dmi_rsp_vld), .dmi_rsp_rdy(dmi_rsp_rdy),
    .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_op(dmi_rsp_op),
    .dm_busy(dm_busy),
    .reg_req_vld(reg_req_vld), .reg_req_rdy(reg_req_rdy), .reg_req_we(reg_req_we),
    .reg_req_addr(reg_req_addr), .reg_req_wdata(reg_req_wdata),
    .reg_rsp_vld(reg_rsp_vld), .reg_rsp_data(reg_rsp_data), .reg_rsp_err(reg_rsp_err)
  );

  always #5 dtm_clk = ~dtm_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge dtm_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [6:0] addr,
                      input logic [31:0] data, input logic busy);
    dmi_req_vld  = 1'b1;
    dmi_req_op   = op;
    dmi_req_addr = addr;
    dmi_req_data = data;
    dm_busy      = busy;
    tick();
    dmi_req_vld  = 1'b0;
    dm_busy      = 1'b0;
  endtask

  task automatic finish_rsp(input string tag);
    dmi_rsp_rdy = 1'b1;
    tick();
    dmi_rsp_rdy = 1'b0;
    chk({tag, "_rsp_drop"}, dmi_rsp_vld, 1'b0);
    chk({tag, "_req_rdy"}, dmi_req_rdy, 1'b1);
  endtask

  task automatic complete(input logic [31:0] data, input logic err);
    reg_rsp_vld  = 1'b1;
    reg_rsp_data = data;
    reg_rsp_err  = err;
    tick();
    reg_rsp_vld  = 1'b0;
    reg_rsp_err  = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_rdy"}, dmi_req_rdy, 1'b1);
    chk({tag, "_rsp"}, {dmi_rsp_vld, dmi_rsp_op, dmi_rsp_data}, 35'h0);
    chk({tag, "_reg"}, {reg_req_vld, reg_req_we, reg_req_addr, reg_req_wdata}, 41'h0);
  endtask

  initial begin
    int n_vld;
    bit seen;
    dmi_rsp_t exp_rsp;

    #12;
    chk_reset_outs("reset");
    dtm_rst_n = 1'b1;
    tick();

    // read with one-cycle accept stall and delayed completion
    send(OP_READ, 7'h10, 32'h0, 1'b0);
    chk("rd_vld_t1", reg_req_vld, 1'b1);
    chk("rd_we_addr", {reg_req_we, reg_req_addr}, {1'b0, 7'h10});
    chk("rd_req_rdy_busy", dmi_req_rdy, 1'b0);
    tick();
    chk("rd_vld_held", reg_req_vld, 1'b1);
    reg_req_rdy = 1'b1;
    tick();
    reg_req_rdy = 1'b0;
    chk("rd_vld_drop", reg_req_vld, 1'b0);
    tick();
    complete(32'hDEADBEEF, 1'b0);
    exp_rsp = '{data: 32'hDEADBEEF, op: RSP_SUCS};
    chk("rd_rsp", {dmi_rsp_vld, dmi_rsp_data, dmi_rsp_op}, {1'b1, exp_rsp});
    finish_rsp("rd");

    // write returning an error
    send(OP_WRITE, 7'h04, 32'h12345678, 1'b0);
    chk("wr_req", {reg_req_vld, reg_req_we, reg_req_addr, reg_req_wdata},
        {1'b1, 1'b1, 7'h04, 32'h12345678});
    reg_req_rdy = 1'b1;
    tick();
    reg_req_rdy = 1'b0;
    complete(32'hFFFFFFFF, 1'b1);
    chk("wr_err_rsp", {dmi_rsp_vld, dmi_rsp_op, dmi_rsp_data}, {1'b1, RSP_FAIL, 32'h0});
    finish_rsp("wr");

    // NOP, reserved, busy: immediate responses with no register access
    send(OP_NOP, 7'h01, 32'h55, 1'b0);
    chk("nop_rsp", {dmi_rsp_vld, dmi_rsp_op, dmi_rsp_data, reg_req_vld},
        {1'b1, RSP_SUCS, 32'h0, 1'b0});
    finish_rsp("nop");
    send(OP_RSVD, 7'h02, 32'h66, 1'b0);
    chk("rsvd_rsp", {dmi_rsp_vld, dmi_rsp_op, dmi_rsp_data, reg_req_vld},
        {1'b1, RSP_FAIL, 32'h0, 1'b0});
    finish_rsp("rsvd");
    send(OP_READ, 7'h03, 32'h0, 1'b1);
    chk("busy_rsp", {dmi_rsp_vld, dmi_rsp_op, dmi_rsp_data, reg_req_vld},
        {1'b1, RSP_BUSY, 32'h0, 1'b0});
    finish_rsp("busy");
    chk("busy_no_access", reg_req_vld, 1'b0);

    // timeout in ISSUE: exactly 8 cycles of reg_req_vld, then fail
    send(OP_READ, 7'h20, 32'h0, 1'b0);
    n_vld = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (dmi_rsp_vld) seen = 1'b1;
      else begin
        if (reg_req_vld) n_vld++;
        tick();
      end
    end
    chk("to_seen", seen, 1'b1);
    chk("to_issue_cycles", n_vld, 8);
    chk("to_rsp", {reg_req_vld, dmi_rsp_op, dmi_rsp_data}, {1'b0, RSP_FAIL, 32'h0});
    complete(32'hCAFE0001, 1'b0);
    chk("stray_in_resp", {dmi_rsp_vld, dmi_rsp_op, dmi_rsp_data}, {1'b1, RSP_FAIL, 32'h0});
    finish_rsp("to");
    complete(32'hCAFE0002, 1'b0);
    chk("stray_in_idle", {dmi_rsp_vld, dmi_req_rdy}, 2'b01);

    // response back-pressure, then back-to-back accept
    send(OP_READ, 7'h11, 32'h0, 1'b0);
    reg_req_rdy = 1'b1;
    tick();
    reg_req_rdy = 1'b0;
    complete(32'hA5A50001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i), {dmi_rsp_vld, dmi_req_rdy, dmi_rsp_op, dmi_rsp_data},
          {1'b1, 1'b0, RSP_SUCS, 32'hA5A50001});
      tick();
    end
    dmi_rsp_rdy = 1'b1;
    tick();
    dmi_rsp_rdy = 1'b0;
    chk("bp_rdy_after", dmi_req_rdy, 1'b1);
    send(OP_NOP, 7'h00, 32'h0, 1'b0);
    chk("b2b_nop", {dmi_rsp_vld, dmi_rsp_op}, {1'b1, RSP_SUCS});
    finish_rsp("b2b");

    // asynchronous reset during WAIT
    send(OP_READ, 7'h12, 32'h0, 1'b0);
    reg_req_rdy = 1'b1;
    tick();
    reg_req_rdy = 1'b0;
    #2 dtm_rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    tick();
    dtm_rst_n = 1'b1;
    tick();
    chk("post_rst_norsp", dmi_rsp_vld, 1'b0);
    send(OP_READ, 7'h13, 32'h0, 1'b0);
    chk("post_rst_req", {reg_req_vld, reg_req_addr}, {1'b1, 7'h13});
    reg_req_rdy = 1'b1;
    tick();
    reg_req_rdy = 1'b0;
    complete(32'h0BADF00D, 1'b0);
    chk("post_rst_rd", {dmi_rsp_vld, dmi_rsp_op, dmi_rsp_data}, {1'b1, RSP_SUCS, 32'h0BADF00D});
    finish_rsp("post_rst");

    // completion in the timeout cycle wins
    send(OP_READ, 7'h14, 32'h0, 1'b0);
    reg_req_rdy = 1'b1;
    tick();
    reg_req_rdy = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("coll_not_yet", dmi_rsp_vld, 1'b0);
    complete(32'h600DD00D, 1'b0);
    chk("coll_rsp", {dmi_rsp_vld, dmi_rsp_op, dmi_rsp_data}, {1'b1, RSP_SUCS, 32'h600DD00D});
    finish_rsp("coll");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
